// File: rtl/seq_divider.sv
// Sequential 16/8 unsigned restoring divider, one quotient bit per clock.
// Divide-by-zero short-circuits to DONE with an all-ones quotient.
module seq_divider (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] dividend,
    input  logic [7:0]  divisor,
    output logic [15:0] quotient,
    output logic [7:0]  remainder,
    output logic        dbz,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  r_cnt;
    logic [15:0] r_dvd;
    logic [7:0]  r_dvs;
    logic [8:0]  r_rem;
    logic [15:0] r_quot;
    logic [7:0]  r_remo;
    logic        r_dbz;

    logic        w_accept;
    logic [8:0]  w_shift;
    logic [9:0]  w_trial;
    logic        w_qbit;
    logic [8:0]  w_rem_nxt;
    logic [15:0] w_dvd_nxt;

    // r_rem[8] becomes the top bit of the shifted 10-bit trial value
    always_comb begin
        w_accept  = start && (r_state != CALC);
        w_shift   = {r_rem[7:0], r_dvd[15]};
        w_trial   = {r_rem[8], w_shift} - {2'b00, r_dvs};
        w_qbit    = ~w_trial[9];
        w_rem_nxt = w_qbit ? w_trial[8:0] : w_shift;
        w_dvd_nxt = {r_dvd[14:0], w_qbit};
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (start) w_next = (divisor == 8'd0) ? DONE : CALC;
            end
            CALC: begin
                if (r_cnt == 4'd15) w_next = DONE;
            end
            DONE: begin
                if (start) w_next = (divisor == 8'd0) ? DONE : CALC;
                else       w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_dvd  <= '0;
            r_dvs  <= '0;
            r_rem  <= '0;
            r_quot <= '0;
            r_remo <= '0;
            r_dbz  <= 1'b0;
        end else if (w_accept) begin
            r_cnt <= '0;
            r_dvd <= dividend;
            r_dvs <= divisor;
            r_rem <= '0;
            if (divisor == 8'd0) begin
                r_quot <= 16'hFFFF;
                r_remo <= dividend[7:0];
                r_dbz  <= 1'b1;
            end
        end else if (r_state == CALC) begin
            r_cnt <= r_cnt + 4'd1;
            r_dvd <= w_dvd_nxt;
            r_rem <= w_rem_nxt;
            if (r_cnt == 4'd15) begin
                r_quot <= w_dvd_nxt;
                r_remo <= w_rem_nxt[7:0];
                r_dbz  <= 1'b0;
            end
        end
    end

    assign quotient  = r_quot;
    assign remainder = r_remo;
    assign dbz       = r_dbz;
    assign busy      = (r_state == CALC);
    assign done      = (r_state == DONE);

endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed: 16-bit dividend, 8-bit divisor, unsigned.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request pulse; operands sampled on the same edge.
REQ-005 dividend  input  16  unsigned numerator.
REQ-006 divisor  input  8  unsigned denominator.
REQ-007 quotient  output  16  registered result, floor(dividend/divisor).
REQ-008 remainder  output  8  registered result, dividend mod divisor.
REQ-009 dbz  output  1  divide-by-zero flag for the last accepted operation.
REQ-010 busy  output  1  high while iterating; start is ignored while high.
REQ-011 done  output  1  one-cycle pulse; results valid in that cycle.

Function
REQ-012 The block SHALL implement restoring division, one quotient bit per clock, MSB first.
REQ-013 The FSM SHALL have three states: IDLE, CALC, DONE.
REQ-014 start=1 in IDLE or DONE SHALL be accepted; operands are captured into internal registers on that edge.
REQ-015 start=1 in CALC SHALL be ignored, with no effect on operands, counter or outputs.
REQ-016 After acceptance, later changes on dividend/divisor SHALL NOT affect the operation in progress.
REQ-017 Accept with divisor!=0: go to CALC, clear the 9-bit partial remainder, reset the 4-bit step counter to 0.
REQ-018 Each CALC step SHALL do the following:
- shift {partial remainder, dividend register} left by 1;
- trial = partial remainder - {1'b0, divisor};
- if trial >= 0, partial remainder = trial and the new quotient LSB = 1; otherwise restore and the LSB = 0.
REQ-019 The partial remainder SHALL be 9 bits wide so the shift cannot overflow for divisor values up to 0xFF.
REQ-020 After the 16th CALC step, the FSM SHALL enter DONE; the 16th step is the edge where the counter wraps 15 -> 0.
REQ-021 Latency: if start is accepted on edge k, the 16 steps occur on edges k+1..k+16 and done=1 during the cycle following edge k+16.
REQ-022 In DONE: done=1, busy=0; with no start, the FSM SHALL return to IDLE on the next edge and done returns to 0.
REQ-023 Accept with divisor==0: skip CALC and go directly to DONE on the next edge with quotient=16'hFFFF, remainder=dividend[7:0] and dbz=1.
REQ-024 For divisor!=0, dbz SHALL be 0 from the DONE cycle onward.
REQ-025 quotient, remainder and dbz SHALL update only on entry to DONE and hold their values through IDLE until the next DONE.
REQ-026 busy SHALL be 1 exactly in CALC (the 16 cycles following acceptance).
REQ-027 start=1 in DONE SHALL begin a new operation on that edge.
REQ-028 On that edge done SHALL fall, and the previous results SHALL hold until the new DONE.
REQ-029 Results SHALL satisfy quotient*divisor + remainder == dividend and remainder < divisor for every divisor!=0.
REQ-030 The block SHALL use no combinational path from inputs to outputs.

Reset
REQ-031 rst_n=0 SHALL immediately, without waiting for a clock, force: state IDLE, busy=0, done=0, dbz=0, quotient=0, remainder=0, counter=0, internal operand and partial-remainder registers=0.
REQ-032 Reset asserted mid-CALC SHALL abort the operation; no done pulse SHALL follow.
REQ-033 After rst_n rises, the first rising edge with start=1 SHALL be accepted normally.

Verification
REQ-034 dividend=0x03E8, divisor=0x07, start pulse -> done 16 cycles after the accepting edge; quotient=0x008E, remainder=0x06, dbz=0.
REQ-035 dividend=0xFFFF, divisor=0xFF -> quotient=0x0101, remainder=0x00; dividend=0x0005, divisor=0x09 -> quotient=0x0000, remainder=0x05.
REQ-036 dividend=0x3039, divisor=0x00 -> done on the edge after acceptance; quotient=0xFFFF, remainder=0x39, dbz=1, busy never 1.
REQ-037 Operation started with 0x0064/0x0A, then start re-pulsed with 0x0001/0x01 during CALC -> the second request is ignored; result is quotient=0x000A, remainder=0x00.
REQ-038 rst_n pulsed low at CALC step 8 -> all outputs 0 asynchronously, no done pulse; a subsequent 0x00FF/0x10 gives quotient=0x000F, remainder=0x0F.
REQ-039 Random regression of at least 10,000 operand pairs including divisor=1, 0xFF and dividend=0 -> check REQ-029 and latency, plus start-in-DONE back-to-back operation.
